// File: rtl/input_vc_arbiter_pkg.sv
// Shared types and helpers for the input VC arbiter: FSM state encoding,
// default geometry and the VC-to-class mapping.
package input_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } arb_state_e;

  localparam int VC_NUM     = 3;
  localparam int PRIO_NUM   = 2;
  localparam int OUTPUT_NUM = 8;
  localparam int VC_TOTAL   = VC_NUM * PRIO_NUM;
  localparam int VC_W       = $clog2(VC_TOTAL);
  localparam int DEST_W     = OUTPUT_NUM;

  function automatic int vc_class(input int i, input int n);
    return i / n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);

  logic [PW-1:0] pos_s;
  logic          take_s;

  // scan N positions starting at ptr; first hit wins
  always_comb begin
    grant  = '0;
    idx    = '0;
    any    = 1'b0;
    pos_s  = '0;
    take_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos_s  = PW'((int'(ptr) + k) % N);
      take_s = !any && req[pos_s];
      idx    = take_s ? pos_s : idx;
      grant  = take_s ? (N'(1) << pos_s) : grant;
      any    = any | take_s;
    end
  end

endmodule

// File: rtl/input_vc_arbiter.sv
// Per-input-port VC arbiter: strict priority across classes, round-robin within
// a class, held until last flit. Optional request timeout: INPUT_ARB_REQ_TIMEOUT_EN.
module input_vc_arbiter
  import input_arb_pkg::*;
#(
  parameter int vc_num     = VC_NUM,
  parameter int prio_num   = PRIO_NUM,
  parameter int output_num = OUTPUT_NUM
`ifdef INPUT_ARB_REQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT    = 16
`endif
) (
  input  logic                                                  clk,
  input  logic                                                  resetn,
  input  logic [vc_num*prio_num-1:0]                            has_packet,
  input  logic [vc_num*prio_num-1:0]                            credit_ok,
  input  logic [vc_num*prio_num*output_num-1:0]                 dest_i,
  input  logic [vc_num*prio_num*$clog2(vc_num*prio_num)-1:0]    output_vc_i,
  input  logic                                                  cts,
  input  logic                                                  last,
  output logic                                                  req,
  output logic [output_num-1:0]                                 req_dest,
  output logic [$clog2(vc_num*prio_num)-1:0]                    req_out_vc,
  output logic [$clog2(vc_num*prio_num)-1:0]                    selected_vc,
  output logic                                                  busy
);

  localparam int NVC   = vc_num * prio_num;
  localparam int VCW   = $clog2(NVC);
  localparam int PTR_W = (vc_num > 1) ? $clog2(vc_num) : 1;
  localparam int CLS_W = (prio_num > 1) ? $clog2(prio_num) : 1;
  localparam logic [NVC-1:0] CLS_MASK = NVC'((1 << vc_num) - 1);

  arb_state_e                     state_r, state_n;
  logic [prio_num-1:0][PTR_W-1:0] ptr_r;
  logic [NVC-1:0]                 elig_s, cls_grant_s, win_oh_s;
  logic [PTR_W-1:0]               cls_idx_s [prio_num];
  logic [prio_num-1:0]            cls_any_s;
  logic                           win_any_s, load_s, adv_s;
  logic [CLS_W-1:0]               win_cls_s, adv_cls_s;
  logic [PTR_W-1:0]               win_loc_s, adv_loc_s;
  logic [VCW-1:0]                 win_vc_s, win_ovc_s;
  logic [output_num-1:0]          win_dest_s;

  assign elig_s = has_packet & credit_ok;

  for (genvar c = 0; c < prio_num; c++) begin : g_cls
    rr_arbiter #(.N(vc_num), .PW(PTR_W)) u_rr (
      .req   (elig_s[c*vc_num +: vc_num]),
      .ptr   (ptr_r[c]),
      .grant (cls_grant_s[c*vc_num +: vc_num]),
      .idx   (cls_idx_s[c]),
      .any   (cls_any_s[c])
    );
  end

  // highest non-empty class overrides lower ones; one-hot winner muxes payload
  always_comb begin
    win_any_s  = 1'b0;
    win_cls_s  = '0;
    win_loc_s  = '0;
    win_oh_s   = '0;
    win_dest_s = '0;
    win_ovc_s  = '0;
    for (int c = 0; c < prio_num; c++) begin
      win_cls_s = cls_any_s[c] ? CLS_W'(c) : win_cls_s;
      win_loc_s = cls_any_s[c] ? cls_idx_s[c] : win_loc_s;
      win_oh_s  = cls_any_s[c] ? (cls_grant_s & (CLS_MASK << (c * vc_num))) : win_oh_s;
      win_any_s = win_any_s | cls_any_s[c];
    end
    for (int i = 0; i < NVC; i++) begin
      win_dest_s = win_dest_s | (dest_i[i*output_num +: output_num] & {output_num{win_oh_s[i]}});
      win_ovc_s  = win_ovc_s | (output_vc_i[i*VCW +: VCW] & {VCW{win_oh_s[i]}});
    end
    win_vc_s = VCW'(int'(win_cls_s) * vc_num + int'(win_loc_s));
  end

  // class and in-class position of the frozen selection, for pointer advance
  always_comb begin
    adv_cls_s = CLS_W'(vc_class(int'(selected_vc), vc_num));
    adv_loc_s = PTR_W'(int'(selected_vc) - vc_class(int'(selected_vc), vc_num) * vc_num);
  end

`ifdef INPUT_ARB_REQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_r;

  // REQ dwell counter, zero on the first REQ cycle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      to_cnt_r <= '0;
    end else if (state_r != REQ) begin
      to_cnt_r <= '0;
    end else begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end
  end
`endif

  // next-state and control decode
  always_comb begin
    state_n = state_r;
    load_s  = 1'b0;
    adv_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (win_any_s) begin
          state_n = REQ;
          load_s  = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      REQ: begin
        if (cts) begin
          adv_s   = 1'b1;
          state_n = last ? IDLE : XFER;
        end else if (!has_packet[selected_vc]) begin
          state_n = IDLE;
`ifdef INPUT_ARB_REQ_TIMEOUT_EN
        end else if (to_cnt_r == TO_W'(TIMEOUT - 1)) begin
          state_n = IDLE;
          adv_s   = 1'b1;
`endif
        end else begin
          state_n = REQ;
        end
      end
      XFER: begin
        if (last) begin
          state_n = IDLE;
        end else begin
          state_n = XFER;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // registered outputs, captured selection and per-class pointers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      req         <= 1'b0;
      busy        <= 1'b0;
      selected_vc <= '0;
      req_dest    <= '0;
      req_out_vc  <= '0;
      ptr_r       <= '0;
    end else begin
      req  <= (state_n == REQ);
      busy <= (state_n == XFER);
      if (load_s) begin
        selected_vc <= win_vc_s;
        req_dest    <= win_dest_s;
        req_out_vc  <= win_ovc_s;
      end
      if (adv_s) begin
        ptr_r[adv_cls_s] <= (adv_loc_s == PTR_W'(vc_num - 1)) ? '0 : adv_loc_s + PTR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_input_vc_arbiter.sv
// Self-checking bench for input_vc_arbiter: directed scenarios plus random
// traffic, all compared against a cycle-level behavioural model.
module tb_input_vc_arbiter;

  localparam int VCN  = 3;
  localparam int PRIO = 2;
  localparam int NVC  = 6;
  localparam int TMO  = 16;

  logic        clk;
  logic        resetn;
  logic [5:0]  has_packet, credit_ok;
  logic [47:0] dest_i;
  logic [17:0] output_vc_i;
  logic        cts, last;
  logic        req, busy;
  logic [7:0]  req_dest;
  logic [2:0]  req_out_vc, selected_vc;

  int tests_run    = 0;
  int tests_failed = 0;

  // model: phase 0 idle, 1 requesting, 2 transferring
  int         m_phase, m_sel, m_ovc, m_wait;
  int         m_ptr [PRIO];
  logic [7:0] m_dest;
  bit         m_req, m_busy;

  input_vc_arbiter dut (
    .clk         (clk),
    .resetn      (resetn),
    .has_packet  (has_packet),
    .credit_ok   (credit_ok),
    .dest_i      (dest_i),
    .output_vc_i (output_vc_i),
    .cts         (cts),
    .last        (last),
    .req         (req),
    .req_dest    (req_dest),
    .req_out_vc  (req_out_vc),
    .selected_vc (selected_vc),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_step();
    int best = -1;
    if (!resetn) begin
      m_phase = 0; m_sel = 0; m_dest = 8'd0; m_ovc = 0; m_wait = 0;
      for (int c = 0; c < PRIO; c++) m_ptr[c] = 0;
    end else begin
      case (m_phase)
        0: begin
          for (int c = PRIO - 1; c >= 0 && best < 0; c--)
            for (int k = 0; k < VCN && best < 0; k++) begin
              int v;
              v = c * VCN + (m_ptr[c] + k) % VCN;
              if (has_packet[v] && credit_ok[v]) best = v;
            end
          if (best >= 0) begin
            m_sel   = best;
            m_dest  = dest_i[best*8 +: 8];
            m_ovc   = int'(output_vc_i[best*3 +: 3]);
            m_phase = 1;
            m_wait  = 0;
          end
        end
        1: begin
          if (cts) begin
            m_ptr[m_sel / VCN] = (m_sel % VCN + 1) % VCN;
            m_phase = last ? 0 : 2;
          end else if (!has_packet[m_sel]) begin
            m_phase = 0;
          end else begin
            m_wait++;
`ifdef INPUT_ARB_REQ_TIMEOUT_EN
            if (m_wait >= TMO) begin
              m_ptr[m_sel / VCN] = (m_sel % VCN + 1) % VCN;
              m_phase = 0;
            end
`endif
          end
        end
        default: if (last) m_phase = 0;
      endcase
    end
    m_req  = (m_phase == 1);
    m_busy = (m_phase == 2);
  endfunction

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("req", req, m_req);
    chk("busy", busy, m_busy);
    chk("selected_vc", selected_vc, m_sel);
    chk("req_dest", req_dest, m_dest);
    chk("req_out_vc", req_out_vc, m_ovc);
  endtask

  task automatic do_reset();
    resetn = 1'b0; cts = 1'b0; last = 1'b0; has_packet = '0; credit_ok = '1;
    step();
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; has_packet = '0; credit_ok = '0; cts = 1'b0; last = 1'b0;
    dest_i = '0; output_vc_i = '0;
    for (int v = 0; v < NVC; v++) begin
      dest_i[v*8 +: 8]      = 8'd1 << v;
      output_vc_i[v*3 +: 3] = 3'(NVC - 1 - v);
    end
    do_reset();
    chk("reset_req", req, 0);
    chk("reset_sel", selected_vc, 0);
    chk("reset_dest", req_dest, 0);

    // priority: class 1 beats class 0
    has_packet = 6'b001001;
    step();
    chk("prio_sel", selected_vc, 3);
    chk("prio_req", req, 1);
    cts = 1'b1; step(); cts = 1'b0;
    step(); step();
    last = 1'b1; has_packet = 6'b000001; step(); last = 1'b0;
    step();
    chk("prio_after_sel", selected_vc, 0);

    // round-robin with single-flit packets
    do_reset();
    has_packet = 6'b000111; cts = 1'b1; last = 1'b1;
    for (int g = 0; g < 4; g++) begin
      step();
      chk("rr_sel", selected_vc, g % 3);
      chk("rr_req", req, 1);
      step();
      chk("rr_gap", req, 0);
    end

    // hold during transfer, late arrival waits for IDLE, then reset mid-XFER
    do_reset();
    dest_i[4*8 +: 8] = 8'b0010_0000; output_vc_i[4*3 +: 3] = 3'd4;
    has_packet = 6'b010000; step();
    chk("hold_sel", selected_vc, 4);
    cts = 1'b1; step(); cts = 1'b0;
    has_packet = 6'b110000;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("hold_busy", busy, 1);
      chk("hold_dest", req_dest, 8'h20);
      chk("hold_ovc", req_out_vc, 4);
    end
    last = 1'b1; has_packet = 6'b100000; step(); last = 1'b0;
    chk("hold_end_busy", busy, 0);
    step();
    chk("hold_next_sel", selected_vc, 5);
    cts = 1'b1; step(); cts = 1'b0;
    resetn = 1'b0; step(); resetn = 1'b1;
    chk("xfer_reset_busy", busy, 0);
    chk("xfer_reset_sel", selected_vc, 0);

    // withdrawal leaves the pointer where it was
    do_reset();
    has_packet = 6'b000010; cts = 1'b1; last = 1'b1; step(); step();
    cts = 1'b0; last = 1'b0;
    has_packet = 6'b000100; step();
    chk("wd_sel", selected_vc, 2);
    has_packet = 6'b000000; step();
    chk("wd_req", req, 0);
    has_packet = 6'b000101; step();
    chk("wd_repick", selected_vc, 2);

    // credit gating
    do_reset();
    has_packet = 6'b000011; credit_ok = 6'b000010; step();
    chk("credit_sel", selected_vc, 1);
    cts = 1'b1; step(); cts = 1'b0;
    credit_ok = 6'b111111; last = 1'b1; has_packet = 6'b000001; step(); last = 1'b0;
    step();
    chk("credit_next", selected_vc, 0);

`ifdef INPUT_ARB_REQ_TIMEOUT_EN
    do_reset();
    has_packet = 6'b011000; step();
    chk("to_sel", selected_vc, 3);
    for (int k = 1; k <= TMO; k++) begin
      step();
      chk("to_req", req, (k < TMO) ? 1 : 0);
    end
    step();
    chk("to_next", selected_vc, 4);
`endif

    // random traffic
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      resetn = ($urandom_range(0, 99) >= 2);
      for (int v = 0; v < NVC; v++) begin
        if (has_packet[v]) has_packet[v] = ($urandom_range(0, 99) >= 8);
        else               has_packet[v] = ($urandom_range(0, 99) < 30);
        credit_ok[v] = ($urandom_range(0, 99) < 80);
        if ($urandom_range(0, 9) == 0) begin
          dest_i[v*8 +: 8]      = 8'd1 << $urandom_range(0, 7);
          output_vc_i[v*3 +: 3] = 3'($urandom_range(0, 5));
        end
      end
      cts  = ($urandom_range(0, 99) < 35);
      last = ($urandom_range(0, 99) < 30);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
